// File: rtl/fb_scanout_sink_if.sv
// Draw-stream bus from the sprite/layer blitter into the framebuffer sink.
// One pixel write per cycle while enable_draw is high; there is no backpressure.
interface fb_scanout_sink_if;
  logic [31:0] draw_x;
  logic [31:0] draw_y;
  logic [31:0] draw_color;
  logic        enable_draw;

  modport master (
    output draw_x,
    output draw_y,
    output draw_color,
    output enable_draw
  );

  modport slave (
    input draw_x,
    input draw_y,
    input draw_color,
    input enable_draw
  );
endinterface

// File: rtl/fb_scanout_sink.sv
// Clipped 160x120 RGB333 framebuffer with 640x480@60 VGA scan-out and 4x4 pixel replication.
// Optional macro FB_DOUBLE_BUFFER_EN: two banks, where a swap is taken at the start of vertical blank.
module fb_scanout_sink #(
  parameter int unsigned FB_WIDTH    = 160,
  parameter int unsigned FB_HEIGHT   = 120,
  parameter int unsigned COLOR_BITS  = 9,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  fb_scanout_sink_if.slave     draw,
  input  logic                 swap_req,
  output logic                 swap_ack,
  output logic [2:0]           vga_r,
  output logic [2:0]           vga_g,
  output logic [2:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic                 frame_start,
  output logic [15:0]          clip_count
);

  localparam int unsigned DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] HS_START = 10'd656;
  localparam logic [9:0] HS_END   = 10'd751;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] VS_START = 10'd490;
  localparam logic [9:0] VS_END   = 10'd491;
  localparam logic [9:0] V_LAST   = 10'd524;

  // ---------------- write path ----------------
  logic                  en_q;
  logic                  in_range_q, in_range_d;
  logic [ADDR_W-1:0]     wx_q, wy_q;
  logic [COLOR_BITS-1:0] wcol_q;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [15:0]           clip_q, clip_d;
  logic                  unused_color_bits;

  assign unused_color_bits = ^draw.draw_color[31:COLOR_BITS];

  // Full-width compare so wrapped negative coordinates fall outside the frame.
  always_comb begin
    in_range_d = (draw.draw_x < FB_WIDTH) && (draw.draw_y < FB_HEIGHT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      en_q       <= draw.enable_draw;
      in_range_q <= in_range_d;
    end
  end

  always_ff @(posedge clk) begin
    wx_q   <= draw.draw_x[ADDR_W-1:0];
    wy_q   <= draw.draw_y[ADDR_W-1:0];
    wcol_q <= draw.draw_color[COLOR_BITS-1:0];
  end

  always_comb begin
    wr_en   = en_q && in_range_q;
    wr_addr = wy_q * ADDR_W'(FB_WIDTH) + wx_q;
    clip_d  = clip_q;
    if (en_q && !in_range_q && (clip_q != '1)) begin
      clip_d = clip_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_q <= '0;
    end else begin
      clip_q <= clip_d;
    end
  end

  assign clip_count = clip_q;

  // ---------------- timing counters ----------------
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       active;
  logic       hs_n;
  logic       vs_n;
  logic       at_origin;

  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end
    active    = (hcount_q < H_ACTIVE) && (vcount_q < V_ACTIVE);
    hs_n      = !((hcount_q >= HS_START) && (hcount_q <= HS_END));
    vs_n      = !((vcount_q >= VS_START) && (vcount_q <= VS_END));
    at_origin = (hcount_q == '0) && (vcount_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // ---------------- read address ----------------
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] rd_row, rd_col;

  always_comb begin
    rd_row  = ADDR_W'(vcount_q >> SCALE_SHIFT);
    rd_col  = ADDR_W'(hcount_q >> SCALE_SHIFT);
    raddr_d = raddr_q;
    if (active) begin
      raddr_d = rd_row * ADDR_W'(FB_WIDTH) + rd_col;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr_q <= '0;
    end else begin
      raddr_q <= raddr_d;
    end
  end

  // ---------------- frame RAM and buffer select ----------------
  logic [COLOR_BITS-1:0] rdata_q;

`ifdef FB_DOUBLE_BUFFER_EN
  logic [COLOR_BITS-1:0] fb_mem [2][DEPTH];
  logic front_q, front_d;
  logic pend_q, pend_d;
  logic swap_take;

  // A request arriving on the swap cycle itself is honoured immediately.
  always_comb begin
    swap_take = (hcount_q == '0) && (vcount_q == V_ACTIVE) && (pend_q || swap_req);
    pend_d    = pend_q || swap_req;
    front_d   = front_q;
    if (swap_take) begin
      pend_d  = 1'b0;
      front_d = ~front_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      front_q <= front_d;
      pend_q  <= pend_d;
    end
  end

  assign swap_ack = swap_take;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fb_mem[~front_q][wr_addr] <= wcol_q;
    end
    rdata_q <= fb_mem[front_q][raddr_d];
  end
`else
  logic [COLOR_BITS-1:0] fb_mem [DEPTH];
  logic unused_swap_req;

  assign unused_swap_req = swap_req;
  assign swap_ack        = 1'b0;

  // Same-address read and write on one edge returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fb_mem[wr_addr] <= wcol_q;
    end
    rdata_q <= fb_mem[raddr_d];
  end
`endif

  // ---------------- output pipeline ----------------
  logic                  act1_q, hs1_q, vs1_q, fs1_q;
  logic                  blank2_q, hs2_q, vs2_q, fs2_q;
  logic [COLOR_BITS-1:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = act1_q ? rdata_q : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act1_q   <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      fs1_q    <= 1'b0;
      blank2_q <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      fs2_q    <= 1'b0;
      rgb_q    <= '0;
    end else begin
      act1_q   <= active;
      hs1_q    <= hs_n;
      vs1_q    <= vs_n;
      fs1_q    <= at_origin;
      blank2_q <= act1_q;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      fs2_q    <= fs1_q;
      rgb_q    <= rgb_d;
    end
  end

  assign vga_r       = rgb_q[COLOR_BITS-1 -: 3];
  assign vga_g       = rgb_q[5:3];
  assign vga_b       = rgb_q[2:0];
  assign vga_hs      = hs2_q;
  assign vga_vs      = vs2_q;
  assign vga_blank_n = blank2_q;
  assign frame_start = fs2_q;

endmodule

// File: tb/tb_fb_scanout_sink.sv
// Directed bench for fb_scanout_sink: write/clip table, scan-out pixel table and timing corner cases.
module tb_fb_scanout_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        swap_req;
  logic        swap_ack;
  logic [2:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start;
  logic [15:0] clip_count;

  always #20 clk = ~clk;

  fb_scanout_sink_if dif ();

  fb_scanout_sink #(
    .FB_WIDTH    (160),
    .FB_HEIGHT   (120),
    .COLOR_BITS  (9),
    .SCALE_SHIFT (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .draw        (dif),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .frame_start (frame_start),
    .clip_count  (clip_count)
  );

  // Pixel index since reset release: pixel n is scanned while cyc==n, shown when cyc==n+2.
  int unsigned cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [8:0]  color;
    logic [15:0] clip;
  } wr_vec_t;

  typedef struct {
    int unsigned line;
    int unsigned col;
    logic [8:0]  rgb;
    logic        bl;
    logic        hs;
  } px_vec_t;

  localparam int NW = 13;
  localparam int NP = 22;
  wr_vec_t wv [NW];
  px_vec_t pv [NP];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    int unsigned guard;
    guard = 0;
    while (cyc < t) begin
      @(negedge clk);
      guard++;
      if (guard > 200000) begin
        n_fail++;
        $display("FAIL wait_cyc timeout: cyc %0d, required %0d", cyc, t);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "bench timeout");
      end
    end
  endtask

  task automatic do_write(input logic [31:0] x, input logic [31:0] y, input logic [8:0] c);
    dif.draw_x      = x;
    dif.draw_y      = y;
    dif.draw_color  = 32'(c);
    dif.enable_draw = 1'b1;
    @(negedge clk);
    dif.enable_draw = 1'b0;
    @(negedge clk);
  endtask

  task automatic burst_clipped(input int unsigned n);
    dif.draw_x      = 32'd200;
    dif.draw_y      = 32'd0;
    dif.draw_color  = 32'h1FF;
    dif.enable_draw = 1'b1;
    repeat (n) @(negedge clk);
    dif.enable_draw = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_pix(input px_vec_t p);
    wait_cyc(p.line * 800 + p.col + 2);
    chk($sformatf("rgb L%0d C%0d", p.line, p.col), 32'({vga_r, vga_g, vga_b}), 32'(p.rgb));
    chk($sformatf("blank_n L%0d C%0d", p.line, p.col), 32'(vga_blank_n), 32'(p.bl));
    chk($sformatf("hs L%0d C%0d", p.line, p.col), 32'(vga_hs), 32'(p.hs));
    chk($sformatf("vs L%0d C%0d", p.line, p.col), 32'(vga_vs), 32'd1);
  endtask

  initial begin
    int unsigned tgt;

    wv[0]  = '{32'd0,          32'd1,          9'h007, 16'd0};
    wv[1]  = '{32'd95,         32'd1,          9'h038, 16'd0};
    wv[2]  = '{32'd10,         32'd0,          9'h007, 16'd0};
    wv[3]  = '{32'd159,        32'd0,          9'h1FF, 16'd0};
    wv[4]  = '{32'd4,          32'd3,          9'h007, 16'd0};
    wv[5]  = '{32'd5,          32'd3,          9'h1C0, 16'd0};
    wv[6]  = '{32'd6,          32'd3,          9'h038, 16'd0};
    wv[7]  = '{32'd5,          32'd4,          9'h1FF, 16'd0};
    wv[8]  = '{32'd160,        32'd0,          9'h1C0, 16'd1};
    wv[9]  = '{32'd0,          32'd120,        9'h1C0, 16'd2};
    wv[10] = '{32'hFFFF_FFFF,  32'd0,          9'h1C0, 16'd3};
    wv[11] = '{32'd159,        32'd119,        9'h1FF, 16'd3};
    wv[12] = '{32'd256,        32'd0,          9'h1C0, 16'd4};

    pv[0]  = '{0,  40,  9'h007, 1'b1, 1'b1};
    pv[1]  = '{0,  41,  9'h1C0, 1'b1, 1'b1};
    pv[2]  = '{0,  43,  9'h1C0, 1'b1, 1'b1};
    pv[3]  = '{0,  640, 9'h000, 1'b0, 1'b1};
    pv[4]  = '{0,  656, 9'h000, 1'b0, 1'b0};
    pv[5]  = '{0,  751, 9'h000, 1'b0, 1'b0};
    pv[6]  = '{0,  752, 9'h000, 1'b0, 1'b1};
    pv[7]  = '{0,  799, 9'h000, 1'b0, 1'b1};
    pv[8]  = '{1,  655, 9'h000, 1'b0, 1'b1};
    pv[9]  = '{1,  656, 9'h000, 1'b0, 1'b0};
    pv[10] = '{3,  42,  9'h1C0, 1'b1, 1'b1};
    pv[11] = '{3,  639, 9'h1FF, 1'b1, 1'b1};
    pv[12] = '{3,  640, 9'h000, 1'b0, 1'b1};
    pv[13] = '{4,  0,   9'h007, 1'b1, 1'b1};
    pv[14] = '{4,  380, 9'h038, 1'b1, 1'b1};
    pv[15] = '{7,  3,   9'h007, 1'b1, 1'b1};
    pv[16] = '{12, 19,  9'h007, 1'b1, 1'b1};
    pv[17] = '{12, 20,  9'h1C0, 1'b1, 1'b1};
    pv[18] = '{12, 23,  9'h1C0, 1'b1, 1'b1};
    pv[19] = '{12, 24,  9'h038, 1'b1, 1'b1};
    pv[20] = '{15, 21,  9'h1C0, 1'b1, 1'b1};
    pv[21] = '{16, 20,  9'h1FF, 1'b1, 1'b1};

    reset           = 1'b1;
    swap_req        = 1'b0;
    dif.draw_x      = '0;
    dif.draw_y      = '0;
    dif.draw_color  = '0;
    dif.enable_draw = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset hs",          32'(vga_hs),      32'd1);
    chk("reset vs",          32'(vga_vs),      32'd1);
    chk("reset blank_n",     32'(vga_blank_n), 32'd0);
    chk("reset rgb",         32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("reset frame_start", 32'(frame_start), 32'd0);
    chk("reset swap_ack",    32'(swap_ack),    32'd0);
    chk("reset clip_count",  32'(clip_count),  32'd0);

    reset    = 1'b0;
    swap_req = 1'b1;

    fork
      begin : drive_thread
        for (int i = 0; i < NW; i++) begin
          do_write(wv[i].x, wv[i].y, wv[i].color);
          chk($sformatf("clip after write %0d", i), 32'(clip_count), 32'(wv[i].clip));
        end
        // Lands on the same edge that first reads address 10 (pixel 40).
        wait_cyc(39);
        do_write(32'd10, 32'd0, 9'h1C0);
        chk("clip after race write", 32'(clip_count), 32'd4);
        burst_clipped(65530);
        chk("clip one below saturation", 32'(clip_count), 32'hFFFE);
        burst_clipped(10);
        chk("clip saturated", 32'(clip_count), 32'hFFFF);
      end
      begin : scan_thread
        wait_cyc(1);
        chk("start blank_n c1",     32'(vga_blank_n), 32'd0);
        chk("start frame_start c1", 32'(frame_start), 32'd0);
        wait_cyc(2);
        chk("start blank_n c2",     32'(vga_blank_n), 32'd1);
        chk("start frame_start c2", 32'(frame_start), 32'd1);
        wait_cyc(3);
        chk("start frame_start c3", 32'(frame_start), 32'd0);
        for (int i = 0; i < NP; i++) begin
          check_pix(pv[i]);
        end
      end
      begin : line_thread
        int lo, act, fs, ack, vsh;
        lo = 0; act = 0; fs = 0; ack = 0; vsh = 0;
        wait_cyc(802);
        for (int i = 0; i < 800; i++) begin
          if (vga_hs == 1'b0)      lo++;
          if (vga_blank_n == 1'b1) act++;
          if (frame_start == 1'b1) fs++;
          if (swap_ack == 1'b1)    ack++;
          if (vga_vs == 1'b1)      vsh++;
          @(negedge clk);
        end
        chk("line1 hs low cycles",   32'(lo),  32'd96);
        chk("line1 active cycles",   32'(act), 32'd640);
        chk("line1 frame_start",     32'(fs),  32'd0);
        chk("line1 swap_ack pulses", 32'(ack), 32'd0);
        chk("line1 vs high cycles",  32'(vsh), 32'd800);
      end
    join

    tgt = (cyc / 800 + 1) * 800 + 300;
    wait_cyc(tgt);
    chk("pre-reset blank_n", 32'(vga_blank_n), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midframe reset hs",          32'(vga_hs),      32'd1);
    chk("midframe reset vs",          32'(vga_vs),      32'd1);
    chk("midframe reset blank_n",     32'(vga_blank_n), 32'd0);
    chk("midframe reset rgb",         32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("midframe reset frame_start", 32'(frame_start), 32'd0);
    chk("midframe reset clip_count",  32'(clip_count),  32'd0);
    reset = 1'b0;

    wait_cyc(1);
    chk("restart blank_n c1", 32'(vga_blank_n), 32'd0);
    wait_cyc(2);
    chk("restart frame_start c2", 32'(frame_start), 32'd1);
    chk("restart blank_n c2",     32'(vga_blank_n), 32'd1);
    wait_cyc(3);
    chk("restart frame_start c3", 32'(frame_start), 32'd0);
    wait_cyc(42);
    chk("restart RAM retained L0 C40", 32'({vga_r, vga_g, vga_b}), 32'h1C0);
    wait_cyc(657);
    chk("restart hs C655", 32'(vga_hs), 32'd1);
    wait_cyc(658);
    chk("restart hs C656", 32'(vga_hs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
